// File: rtl/saturn_rstk_exec_if.sv
// saturn_rstk_exec_if: signals between the return-stack execution stage and
// the surrounding core (decoder strobes, call-logic pushes, PC/C write-back
// requests and status flags).
// The master modport is the core/decoder side. The slave modport is the
// execution stage.
interface saturn_rstk_exec_if #(
  parameter int ADDR_W = 20
);
  // Decoder and control inputs to the stage
  logic              i_en_exec;
  logic              i_stalled;
  logic              i_ins_decoded;
  logic [ADDR_W-1:0] i_ins_addr;
  logic              i_direction;
  logic              i_ins_rtn;
  logic              i_set_xm;
  logic              i_set_carry;
  logic              i_carry_val;
  logic              i_ins_set_mode;
  logic              i_mode_dec;
  logic              i_ins_rstk_c;
  logic [ADDR_W-1:0] i_reg_c;
  logic              i_push_req;
  logic [ADDR_W-1:0] i_push_addr;

  // Results and status driven back to the core
  logic              o_busy;
  logic              o_done;
  logic              o_pc_load;
  logic [ADDR_W-1:0] o_pc_value;
  logic              o_c_load;
  logic [ADDR_W-1:0] o_c_value;
  logic              o_carry;
  logic              o_xm;
  logic              o_mode_dec;
  logic [4:0]        o_rstk_depth;
  logic              o_exec_error;
  logic [ADDR_W-1:0] o_err_addr;
  logic              o_rstk_ovf;
  logic              o_rstk_udf;

  modport master (
    output i_en_exec, i_stalled, i_ins_decoded, i_ins_addr, i_direction,
           i_ins_rtn, i_set_xm, i_set_carry, i_carry_val, i_ins_set_mode,
           i_mode_dec, i_ins_rstk_c, i_reg_c, i_push_req, i_push_addr,
    input  o_busy, o_done, o_pc_load, o_pc_value, o_c_load, o_c_value,
           o_carry, o_xm, o_mode_dec, o_rstk_depth, o_exec_error, o_err_addr,
           o_rstk_ovf, o_rstk_udf
  );

  modport slave (
    input  i_en_exec, i_stalled, i_ins_decoded, i_ins_addr, i_direction,
           i_ins_rtn, i_set_xm, i_set_carry, i_carry_val, i_ins_set_mode,
           i_mode_dec, i_ins_rstk_c, i_reg_c, i_push_req, i_push_addr,
    output o_busy, o_done, o_pc_load, o_pc_value, o_c_load, o_c_value,
           o_carry, o_xm, o_mode_dec, o_rstk_depth, o_exec_error, o_err_addr,
           o_rstk_ovf, o_rstk_udf
  );
endinterface

// File: rtl/saturn_rstk_exec.sv
// saturn_rstk_exec: Saturn execution stage for the RTN family, SETHEX/SETDEC
// and RSTK=C / C=RSTK. It owns the circular hardware return stack and the
// XM, carry and decimal-mode status bits.
// Optional feature macro: SATURN_RSTK_STATUS_EN. When it is defined, sticky
// overflow/underflow flags are built. When it is undefined, those outputs
// are tied to 0.
// Reset is synchronous and active-low (i_reset).
module saturn_rstk_exec #(
  parameter int RSTK_DEPTH = 8,
  parameter int ADDR_W     = 20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  saturn_rstk_exec_if.slave bus
);

  localparam int         PTR_W      = $clog2(RSTK_DEPTH);
  localparam logic [4:0] DEPTH_FULL = 5'(RSTK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RTN    = 2'd0,
    OP_POP_C  = 2'd1,
    OP_PUSH_C = 2'd2
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              set_xm_q, set_xm_d;
  logic              set_carry_q, set_carry_d;
  logic              carry_val_q, carry_val_d;
  logic [ADDR_W-1:0] operand_q, operand_d;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [4:0]        depth_q, depth_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_value_q, pc_value_d;
  logic              c_load_q, c_load_d;
  logic [ADDR_W-1:0] c_value_q, c_value_d;
  logic              carry_q, carry_d;
  logic              xm_q, xm_d;
  logic              mode_dec_q, mode_dec_d;
  logic              exec_error_q, exec_error_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              advance;
  logic [1:0]        op_count;
  logic              op_onehot;
  logic              push_en;
  logic [ADDR_W-1:0] push_data;
  logic              pop_en;
  logic              stack_full;
  logic              stack_empty;
  logic [ADDR_W-1:0] rd_data;
  logic [ADDR_W-1:0] pop_value;

  // Stack storage; ptr_q is the next free slot, so the top is ptr_q - 1.
  logic [ADDR_W-1:0] stack_mem [RSTK_DEPTH];

  assign advance     = bus.i_en_exec & ~bus.i_stalled;
  assign op_count    = {1'b0, bus.i_ins_rtn} + {1'b0, bus.i_ins_set_mode} +
                       {1'b0, bus.i_ins_rstk_c};
  assign op_onehot   = (op_count == 2'd1);
  assign stack_full  = (depth_q == DEPTH_FULL);
  assign stack_empty = (depth_q == 5'd0);
  assign rd_data     = stack_mem[ptr_q - PTR_W'(1)];
  // An empty-stack pop returns 0 instead of stale RAM contents.
  assign pop_value   = stack_empty ? '0 : rd_data;

  // Next-state and output decode. Everything holds unless the stage advances.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    set_xm_d     = set_xm_q;
    set_carry_d  = set_carry_q;
    carry_val_d  = carry_val_q;
    operand_d    = operand_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pc_load_d    = pc_load_q;
    pc_value_d   = pc_value_q;
    c_load_d     = c_load_q;
    c_value_d    = c_value_q;
    carry_d      = carry_q;
    xm_d         = xm_q;
    mode_dec_d   = mode_dec_q;
    exec_error_d = exec_error_q;
    err_addr_d   = err_addr_q;
    push_en      = 1'b0;
    push_data    = bus.i_push_addr;
    pop_en       = 1'b0;

    if (advance) begin
      done_d       = 1'b0;
      pc_load_d    = 1'b0;
      c_load_d     = 1'b0;
      exec_error_d = 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.i_ins_decoded) begin
            if (op_onehot) begin
              if (bus.i_ins_set_mode) begin
                // Mode switches complete in the accepting cycle.
                mode_dec_d = bus.i_mode_dec;
                done_d     = 1'b1;
              end else begin
                op_d        = bus.i_ins_rtn ? OP_RTN :
                              (bus.i_direction ? OP_POP_C : OP_PUSH_C);
                set_xm_d    = bus.i_set_xm;
                set_carry_d = bus.i_set_carry;
                carry_val_d = bus.i_carry_val;
                operand_d   = bus.i_reg_c;
                busy_d      = 1'b1;
                state_d     = S_EXEC;
              end
              // A call push colliding with a valid instruction is dropped.
              if (bus.i_push_req) begin
                exec_error_d = 1'b1;
                err_addr_d   = bus.i_push_addr;
              end
            end else begin
              // Malformed decode: report it. A colliding push is dropped too.
              exec_error_d = 1'b1;
              err_addr_d   = bus.i_ins_addr;
            end
          end else if (bus.i_push_req) begin
            push_en   = 1'b1;
            push_data = bus.i_push_addr;
          end
        end

        S_EXEC: begin
          if (op_q == OP_RTN) begin
            pop_en     = 1'b1;
            pc_value_d = pop_value;
            pc_load_d  = 1'b1;
            if (set_xm_q) begin
              xm_d = 1'b1;
            end
            if (set_carry_q) begin
              carry_d = carry_val_q;
            end
          end else if (op_q == OP_POP_C) begin
            pop_en    = 1'b1;
            c_value_d = pop_value;
            c_load_d  = 1'b1;
          end else begin
            push_en   = 1'b1;
            push_data = operand_q;
          end
          state_d = S_DONE;
          if (bus.i_ins_decoded) begin
            exec_error_d = 1'b1;
            err_addr_d   = bus.i_ins_addr;
          end else if (bus.i_push_req) begin
            exec_error_d = 1'b1;
            err_addr_d   = bus.i_push_addr;
          end
        end

        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          // Busy is still visible this cycle, so arrivals count as conflicts.
          if (bus.i_ins_decoded) begin
            exec_error_d = 1'b1;
            err_addr_d   = bus.i_ins_addr;
          end else if (bus.i_push_req) begin
            exec_error_d = 1'b1;
            err_addr_d   = bus.i_push_addr;
          end
        end

        default: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Pointer and depth update. A full push wraps over the oldest entry.
  // An empty pop leaves both the pointer and the depth unchanged.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    if (push_en) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!stack_full) begin
        depth_d = depth_q + 5'd1;
      end
    end else if (pop_en && !stack_empty) begin
      ptr_d   = ptr_q - PTR_W'(1);
      depth_d = depth_q - 5'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stack RAM write port. Contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (push_en) begin
      stack_mem[ptr_q] <= push_data;
    end
  end

  // Latched operands, stack bookkeeping and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      op_q         <= OP_RTN;
      set_xm_q     <= 1'b0;
      set_carry_q  <= 1'b0;
      carry_val_q  <= 1'b0;
      operand_q    <= '0;
      ptr_q        <= '0;
      depth_q      <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_value_q   <= '0;
      c_load_q     <= 1'b0;
      c_value_q    <= '0;
      carry_q      <= 1'b0;
      xm_q         <= 1'b0;
      mode_dec_q   <= 1'b0;
      exec_error_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      op_q         <= op_d;
      set_xm_q     <= set_xm_d;
      set_carry_q  <= set_carry_d;
      carry_val_q  <= carry_val_d;
      operand_q    <= operand_d;
      ptr_q        <= ptr_d;
      depth_q      <= depth_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pc_load_q    <= pc_load_d;
      pc_value_q   <= pc_value_d;
      c_load_q     <= c_load_d;
      c_value_q    <= c_value_d;
      carry_q      <= carry_d;
      xm_q         <= xm_d;
      mode_dec_q   <= mode_dec_d;
      exec_error_q <= exec_error_d;
      err_addr_q   <= err_addr_d;
    end
  end

`ifdef SATURN_RSTK_STATUS_EN
  logic ovf_q;
  logic udf_q;

  // Sticky overflow/underflow flags. Only reset clears them.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push_en && stack_full) begin
        ovf_q <= 1'b1;
      end
      if (pop_en && stack_empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign bus.o_rstk_ovf = ovf_q;
  assign bus.o_rstk_udf = udf_q;
`else
  assign bus.o_rstk_ovf = 1'b0;
  assign bus.o_rstk_udf = 1'b0;
`endif

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_pc_load    = pc_load_q;
  assign bus.o_pc_value   = pc_value_q;
  assign bus.o_c_load     = c_load_q;
  assign bus.o_c_value    = c_value_q;
  assign bus.o_carry      = carry_q;
  assign bus.o_xm         = xm_q;
  assign bus.o_mode_dec   = mode_dec_q;
  assign bus.o_rstk_depth = depth_q;
  assign bus.o_exec_error = exec_error_q;
  assign bus.o_err_addr   = err_addr_q;

endmodule

// File: doc/saturn_rstk_exec.md
Name: saturn_rstk_exec

Overview:
- Execution stage directly downstream of the Saturn nibble decoder.
- Consumes one-cycle decoded control-instruction flags and executes the following instructions:
  - RTN family: RTNSXM, RTN, RTNSC, RTNCC.
  - SETHEX, SETDEC.
  - RSTK=C, C=RSTK.
- Owns the hardware return stack, the XM, carry and decimal-mode status bits.
- Drives PC reload and C-register write-back requests to the rest of the core.

Parameters:
- RSTK_DEPTH, 8: number of return-stack entries; must be a power of two, 2..16.
- ADDR_W, 20: width of each stack entry, PC and C-low field, in bits.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_en_exec  in  1  execute-phase enable; FSM advances only when high.
- i_stalled  in  1  global stall; when high, all state and outputs hold.
- i_ins_decoded  in  1  decoder output valid strobe.
- i_ins_addr  in  ADDR_W  address of the decoded instruction (used for error report).
- i_direction  in  1  RSTK/C direction: 0 = RSTK=C, 1 = C=RSTK.
- i_ins_rtn  in  1  RTN-family instruction.
- i_set_xm  in  1  RTN also sets XM.
- i_set_carry  in  1  RTN also writes carry.
- i_carry_val  in  1  carry value to write.
- i_ins_set_mode  in  1  SETHEX/SETDEC instruction.
- i_mode_dec  in  1  1 = SETDEC, 0 = SETHEX.
- i_ins_rstk_c  in  1  RSTK=C or C=RSTK instruction.
- i_reg_c  in  ADDR_W  low field of register C.
- i_push_req  in  1  push request from call logic (GOSUB).
- i_push_addr  in  ADDR_W  return address to push on a call.
- o_busy  out  1  instruction in progress; decoder must stall while high.
- o_done  out  1  one-cycle completion pulse.
- o_pc_load  out  1  one-cycle request to load PC from o_pc_value.
- o_pc_value  out  ADDR_W  popped return address.
- o_c_load  out  1  one-cycle request to write o_c_value into C[19:0].
- o_c_value  out  ADDR_W  popped value for C.
- o_carry  out  1  carry flag.
- o_xm  out  1  XM flag, sticky.
- o_mode_dec  out  1  arithmetic mode: 1 = decimal, 0 = hex.
- o_rstk_depth  out  5  number of valid stack entries, 0..RSTK_DEPTH.
- o_exec_error  out  1  one-cycle error pulse.
- o_err_addr  out  ADDR_W  i_ins_addr of the offending instruction.
- o_rstk_ovf  out  1  sticky overflow flag (optional feature).
- o_rstk_udf  out  1  sticky underflow flag (optional feature).

Behaviour:
- Reset (i_reset == 0 at a rising edge):
  - All outputs go to 0, including o_mode_dec = 0 (HEX), o_rstk_depth = 0, o_pc_value = 0 and o_c_value = 0.
  - The stack pointer clears and the FSM returns to S_IDLE.
  - Stack RAM contents are don't-care.
  - Reset mid-operation aborts the instruction; no load pulse is ever issued for it.
- Stall: while i_stalled == 1 or i_en_exec == 0, the FSM, stack and every output register hold. Pulse outputs are also held, not cleared.
- Pulse clearing: o_pc_load, o_c_load, o_done and o_exec_error are cleared on every advancing cycle unless set in that cycle.
- FSM has 3 states: S_IDLE, S_EXEC, S_DONE.
- S_IDLE:
  - On i_ins_decoded with exactly one of i_ins_rtn / i_ins_set_mode / i_ins_rstk_c set: latch the op and operands, set o_busy = 1, go to S_EXEC.
  - SETHEX/SETDEC is the exception: o_mode_dec <= i_mode_dec and o_done pulses in that same cycle. Total latency is 1 cycle; state stays S_IDLE and o_busy stays 0.
  - If i_ins_decoded has zero or more than one op flag set: o_exec_error pulses, o_err_addr <= i_ins_addr, nothing else changes.
  - If i_push_req occurs without i_ins_decoded: push i_push_addr, depth increments, done in 1 cycle, no o_done pulse.
  - If i_push_req and i_ins_decoded occur in the same cycle: the instruction wins, the push is dropped, and o_exec_error pulses with o_err_addr <= i_push_addr.
- S_EXEC (one advancing cycle after acceptance):
  - RTN: pop into o_pc_value and pulse o_pc_load.
    - If set_xm: o_xm <= 1.
    - If set_carry: o_carry <= carry_val.
    - Otherwise carry holds.
  - C=RSTK: pop into o_c_value and pulse o_c_load.
  - RSTK=C: push the latched i_reg_c.
  - Go to S_DONE.
- S_DONE: pulse o_done, set o_busy = 0, go to S_IDLE. An instruction arriving here is accepted only on the following cycle.
- Busy conflict: i_ins_decoded or i_push_req arriving while o_busy == 1 is dropped, and o_exec_error pulses with the offending address.
- Latency: RTN, RSTK=C and C=RSTK take 3 advancing cycles from acceptance to o_done. The load pulse appears 1 cycle before o_done.
- Stack organisation: circular buffer with top pointer, log2(RSTK_DEPTH) bits, wrapping modulo RSTK_DEPTH.
- Push when depth == RSTK_DEPTH: the oldest entry is overwritten and depth stays at RSTK_DEPTH (Saturn semantics).
- Pop when depth == 0: the value is 0, the load pulse is still issued, and depth stays 0.
- Otherwise depth increments or decrements by exactly 1 per push or pop.

Optional Feature:
- Macro: SATURN_RSTK_STATUS_EN.
- Defined:
  - o_rstk_ovf is set on any push at full depth.
  - o_rstk_udf is set on any pop at depth 0.
  - Both flags are sticky until reset.
- Undefined: both ports are tied to 0 and no flag registers are synthesised. All other behaviour is identical.

Test Plan:
- Reset, then RSTK=C with C = 20'h12345, then RTN -> o_pc_load pulses with o_pc_value = 12345, o_rstk_depth goes 0->1->0, o_carry = 0, o_xm = 0.
- SETDEC then SETHEX -> o_mode_dec = 1 after the first cycle and 0 after the second; o_busy never asserts.
- 9 pushes of 0x00001..0x00009 with RSTK_DEPTH = 8, then 9 C=RSTK -> pops return 9,8,...,2 then 0; depth saturates at 8 and bottoms at 0; with SATURN_RSTK_STATUS_EN, o_rstk_ovf = 1 and o_rstk_udf = 1.
- RTNSC after pushing 0xABCDE -> o_carry = 1, o_pc_value = ABCDE; then RTNSXM on an empty stack -> o_xm = 1, o_pc_value = 0, o_carry still 1.
- i_ins_decoded (RTN) and i_push_req same cycle; i_stalled held high 3 cycles during S_EXEC -> o_exec_error pulses with o_err_addr = i_push_addr; outputs frozen during the stall; o_done arrives 3 cycles later than unstalled.
- i_reset driven low while in S_EXEC -> no o_pc_load/o_c_load pulse; o_rstk_depth = 0 and o_busy = 0 on the next cycle.
